// File: rtl/kmeans_k2n2_acc_if.sv
// rtl/kmeans_k2n2_acc_if.sv - sample/centroid bus between the kmeans pipeline and the centroid accumulator
interface kmeans_k2n2_acc_if #(
    parameter int data_width = 16
);
    logic                  start;
    logic                  in_valid;
    logic [data_width-1:0] in_d0;
    logic [data_width-1:0] in_d1;
    logic                  in_k;
    logic [data_width-1:0] cur_k0_0;
    logic [data_width-1:0] cur_k0_1;
    logic [data_width-1:0] cur_k1_0;
    logic [data_width-1:0] cur_k1_1;
    logic [data_width-1:0] new_k0_0;
    logic [data_width-1:0] new_k0_1;
    logic [data_width-1:0] new_k1_0;
    logic [data_width-1:0] new_k1_1;
    logic                  out_valid;
    logic                  busy;
    logic                  converged;

    modport master (
        output start, in_valid, in_d0, in_d1, in_k,
        output cur_k0_0, cur_k0_1, cur_k1_0, cur_k1_1,
        input  new_k0_0, new_k0_1, new_k1_0, new_k1_1,
        input  out_valid, busy, converged
    );

    modport slave (
        input  start, in_valid, in_d0, in_d1, in_k,
        input  cur_k0_0, cur_k0_1, cur_k1_0, cur_k1_1,
        output new_k0_0, new_k0_1, new_k1_0, new_k1_1,
        output out_valid, busy, converged
    );
endinterface

// File: rtl/kmeans_k2n2_acc.sv
// rtl/kmeans_k2n2_acc.sv - k=2, 2-D centroid accumulator with serial restoring divider (optional KMEANS_ACC_CONVERGE_EN)
module kmeans_k2n2_acc #(
    parameter int data_width           = 16,
    parameter int n_input_data_b_depth = 8,
    parameter int n_input_data         = 256
) (
    input logic              clk,
    input logic              rst,
    kmeans_k2n2_acc_if.slave bus
);
    localparam int acc_width = data_width + n_input_data_b_depth;
    localparam int cnt_width = n_input_data_b_depth + 1;
    localparam int bit_width = $clog2(acc_width);
    localparam logic [bit_width-1:0] BIT_LAST = bit_width'(acc_width - 1);
    localparam logic [cnt_width-1:0] ACC_LAST = cnt_width'(n_input_data - 1);

    typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

    state_t                state_q;
    // sum index = {cluster, coordinate}
    logic [acc_width-1:0]  sum_q [4];
    logic [cnt_width-1:0]  cnt_q [2];
    logic [cnt_width-1:0]  acc_cnt_q;
    logic [1:0]            slot_q;
    logic [bit_width-1:0]  bit_q;
    logic [acc_width-1:0]  dvd_q;
    logic [acc_width-1:0]  rem_q;
    logic [data_width-1:0] quo_q;
    logic [data_width-1:0] res_q [3];
    logic [data_width-1:0] new_q [4];
    logic                  out_valid_q;
    logic                  busy_q;

    logic [data_width-1:0] cur_sel;
    logic [acc_width-1:0]  sel_sum;
    logic [cnt_width-1:0]  sel_cnt;
    logic [acc_width-1:0]  dvd_in;
    logic [acc_width-1:0]  rem_in;
    logic [data_width-1:0] quo_in;
    logic [acc_width:0]    trial;
    logic [acc_width:0]    diff;
    logic                  qbit;
    logic [acc_width-1:0]  dvd_d;
    logic [acc_width-1:0]  rem_d;
    logic [data_width-1:0] quo_d;
    logic [data_width-1:0] result_d;

    // One restoring-divider step for the current slot; a new slot restarts from the selected sum.
    // Only the low data_width quotient bits are kept, which is exactly the truncated result.
    always_comb begin
        cur_sel = bus.cur_k0_0;
        case (slot_q)
            2'd0: cur_sel = bus.cur_k0_0;
            2'd1: cur_sel = bus.cur_k0_1;
            2'd2: cur_sel = bus.cur_k1_0;
            default: cur_sel = bus.cur_k1_1;
        endcase
        sel_sum  = sum_q[slot_q];
        sel_cnt  = cnt_q[slot_q[1]];
        dvd_in   = (bit_q == '0) ? sel_sum : dvd_q;
        rem_in   = (bit_q == '0) ? '0 : rem_q;
        quo_in   = (bit_q == '0) ? '0 : quo_q;
        trial    = {rem_in, dvd_in[acc_width-1]};
        diff     = trial - {{data_width{1'b0}}, sel_cnt};
        qbit     = ~diff[acc_width];
        rem_d    = qbit ? diff[acc_width-1:0] : trial[acc_width-1:0];
        quo_d    = {quo_in[data_width-2:0], qbit};
        dvd_d    = {dvd_in[acc_width-2:0], 1'b0};
        result_d = (sel_cnt == '0) ? cur_sel : quo_d;
    end

`ifdef KMEANS_ACC_CONVERGE_EN
    logic converged_q;
`endif

    // Control FSM, accumulation, divider sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < 4; i++) sum_q[i] <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
            for (int i = 0; i < 3; i++) res_q[i] <= '0;
            for (int i = 0; i < 4; i++) new_q[i] <= '0;
            acc_cnt_q   <= '0;
            slot_q      <= '0;
            bit_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef KMEANS_ACC_CONVERGE_EN
            converged_q <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 4; i++) sum_q[i] <= '0;
                        for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
                        acc_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ACC;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        sum_q[{bus.in_k, 1'b0}] <= sum_q[{bus.in_k, 1'b0}]
                                                   + {{n_input_data_b_depth{1'b0}}, bus.in_d0};
                        sum_q[{bus.in_k, 1'b1}] <= sum_q[{bus.in_k, 1'b1}]
                                                   + {{n_input_data_b_depth{1'b0}}, bus.in_d1};
                        cnt_q[bus.in_k] <= cnt_q[bus.in_k] + 1'b1;
                        acc_cnt_q       <= acc_cnt_q + 1'b1;
                        if (acc_cnt_q == ACC_LAST) begin
                            slot_q  <= '0;
                            bit_q   <= '0;
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (bit_q == BIT_LAST) begin
                        bit_q <= '0;
                        case (slot_q)
                            2'd0: res_q[0] <= result_d;
                            2'd1: res_q[1] <= result_d;
                            2'd2: res_q[2] <= result_d;
                            default: begin
                                new_q[0]    <= res_q[0];
                                new_q[1]    <= res_q[1];
                                new_q[2]    <= res_q[2];
                                new_q[3]    <= result_d;
                                out_valid_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= DONE;
`ifdef KMEANS_ACC_CONVERGE_EN
                                converged_q <= (res_q[0] == bus.cur_k0_0) && (res_q[1] == bus.cur_k0_1)
                                            && (res_q[2] == bus.cur_k1_0) && (result_d == bus.cur_k1_1);
`endif
                            end
                        endcase
                        slot_q <= slot_q + 1'b1;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.new_k0_0  = new_q[0];
    assign bus.new_k0_1  = new_q[1];
    assign bus.new_k1_0  = new_q[2];
    assign bus.new_k1_1  = new_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
`ifdef KMEANS_ACC_CONVERGE_EN
    assign bus.converged = converged_q;
`else
    assign bus.converged = 1'b0;
`endif
endmodule

// File: tb/tb_kmeans_k2n2_acc.sv
// tb/tb_kmeans_k2n2_acc.sv - scoreboard bench for kmeans_k2n2_acc
module tb_kmeans_k2n2_acc;
`ifdef KMEANS_ACC_CONVERGE_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif
    localparam int DIV_LAT = 73;

    typedef struct {
        logic [15:0] e00, e01, e10, e11;
        logic        conv;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   last_t = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    kmeans_k2n2_acc_if #(.data_width(16)) bus();

    kmeans_k2n2_acc #(
        .data_width(16),
        .n_input_data_b_depth(2),
        .n_input_data(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_valid_cycle", cyc, e.cyc);
                chk("new_k0_0", bus.new_k0_0, e.e00);
                chk("new_k0_1", bus.new_k0_1, e.e01);
                chk("new_k1_0", bus.new_k1_0, e.e10);
                chk("new_k1_1", bus.new_k1_1, e.e11);
                chk("converged", bus.converged, e.conv);
                chk("busy_at_done", bus.busy, 0);
            end
        end
    end

    task automatic set_cur(input logic [15:0] a, b, c, d);
        bus.cur_k0_0 = a; bus.cur_k0_1 = b; bus.cur_k1_0 = c; bus.cur_k1_1 = d;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d0, d1, input logic k, input int gap);
        bus.in_valid = 1'b1; bus.in_d0 = d0; bus.in_d1 = d1; bus.in_k = k;
        last_t = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic push_exp(input logic [15:0] a, b, c, d, input logic conv);
        exp_t e;
        e.e00 = a; e.e01 = b; e.e10 = c; e.e11 = d; e.conv = conv;
        e.cyc = last_t + DIV_LAT;
        exp_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            chk("timeout_out_valid", 0, 1);
            exp_q.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic basic_samples(input int gap);
        send(16'd1, 16'd1, 1'b0, gap);
        send(16'd3, 16'd3, 1'b0, gap);
        send(16'd10, 16'd20, 1'b1, gap);
        send(16'd12, 16'd22, 1'b1, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_new_k0_0"}, bus.new_k0_0, 0);
        chk({tag, "_new_k0_1"}, bus.new_k0_1, 0);
        chk({tag, "_new_k1_0"}, bus.new_k1_0, 0);
        chk({tag, "_new_k1_1"}, bus.new_k1_1, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_converged"}, bus.converged, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_d0 = '0; bus.in_d1 = '0; bus.in_k = 1'b0;
        set_cur(16'd0, 16'd0, 16'd1, 16'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cleared("reset");

        // Basic update; in_valid noise in IDLE must be ignored.
        send(16'd50, 16'd50, 1'b1, 0);
        do_start();
        chk("busy_in_acc", bus.busy, 1);
        basic_samples(0);
        push_exp(16'd2, 16'd2, 16'd11, 16'd21, 1'b0);
        chk("busy_in_div", bus.busy, 1);
        wait_done();
        chk("busy_idle", bus.busy, 0);

        // Empty cluster 1 keeps its current centroid; gaps between samples.
        set_cur(16'd9, 16'd9, 16'd100, 16'd200);
        do_start();
        send(16'd4, 16'd6, 1'b0, 2);
        send(16'd5, 16'd7, 1'b0, 1);
        send(16'd6, 16'd8, 1'b0, 3);
        send(16'd7, 16'd9, 1'b0, 0);
        push_exp(16'd5, 16'd7, 16'd100, 16'd200, 1'b0);
        wait_done();

        // Convergence: result equals the current centroids; start mid-ACC ignored.
        set_cur(16'd2, 16'd2, 16'd11, 16'd21);
        do_start();
        send(16'd1, 16'd1, 1'b0, 0);
        do_start();
        send(16'd3, 16'd3, 1'b0, 1);
        send(16'd10, 16'd20, 1'b1, 0);
        send(16'd12, 16'd22, 1'b1, 0);
        push_exp(16'd2, 16'd2, 16'd11, 16'd21, CONV_EN);
        wait_done();
        chk("converged_hold", bus.converged, CONV_EN);
        chk("new_hold_k1_1", bus.new_k1_1, 21);

        // Differing result clears converged.
        set_cur(16'd0, 16'd0, 16'd1, 16'd1);
        do_start();
        basic_samples(1);
        push_exp(16'd2, 16'd2, 16'd11, 16'd21, 1'b0);
        wait_done();

        // Reset after two accepted samples, then a clean run.
        do_start();
        send(16'd7, 16'd7, 1'b1, 0);
        send(16'd9, 16'd9, 1'b0, 0);
        pulse_rst();
        chk_cleared("rst_acc");
        send(16'd60, 16'd60, 1'b0, 0);
        do_start();
        basic_samples(0);
        push_exp(16'd2, 16'd2, 16'd11, 16'd21, 1'b0);
        wait_done();

        // Reset at DIV cycle 30: no result, outputs cleared, back in IDLE.
        do_start();
        basic_samples(0);
        repeat (30) begin @(posedge clk); #1; end
        pulse_rst();
        repeat (100) begin @(posedge clk); #1; end
        chk_cleared("rst_div");

        // A following run still gives the basic result.
        do_start();
        basic_samples(0);
        push_exp(16'd2, 16'd2, 16'd11, 16'd21, 1'b0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
